pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Sequential consumer of the NextPC value produced by the next-PC logic.
- Holds the architectural PC register and issues instruction-memory fetches with a req/ready handshake.
- Presents the fetched instruction to decode and advances to NextPC when the core signals retirement.
- Flags misaligned targets and fetch timeouts as sticky faults.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- TIMEOUT, 16, max cycles imem_req may wait for imem_ready; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- NextPC  input  64  target PC from the next-PC logic for the instruction currently held.
- Advance  input  1  core retires the held instruction; sampled only in HOLD.
- imem_req  output  1  fetch request, held high until accepted.
- imem_addr  output  64  fetch address; equals CurrentPC while imem_req=1.
- imem_ready  input  1  memory returns imem_rdata this cycle; sampled only in REQ.
- imem_rdata  input  32  instruction word.
- CurrentPC  output  64  PC of the instruction being fetched or held.
- Instr  output  32  registered instruction word.
- InstrValid  output  1  Instr is valid for CurrentPC.
- Fault  output  1  sticky fault indicator.
- FaultCode  output  2  00 none, 01 misaligned NextPC, 10 fetch timeout.
- RetiredCount  output  CNT_W  number of Advance events accepted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high; overrides every other input in the same cycle):
  - state=IDLE, CurrentPC=RESET_PC, Instr=0, InstrValid=0, imem_req=0, Fault=0, FaultCode=00, RetiredCount=0, timeout counter=0.
  - A Reset asserted mid-REQ drops imem_req at that same edge; a late imem_ready is ignored.
- IDLE: lasts one cycle after Reset deasserts, then goes to REQ. If RESET_PC[1:0]!=0, goes to FAULT with code 01 instead.
- REQ:
  - imem_req=1 and imem_addr=CurrentPC, combinationally from state.
  - imem_ready=1: Instr<=imem_rdata, InstrValid<=1, timeout counter<=0, next state HOLD. Minimum fetch latency is 1 cycle (req and ready in the same cycle).
  - imem_ready=0: timeout counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with ready still low, the next state is FAULT, code 10.
- HOLD:
  - imem_req=0; InstrValid=1; Instr and CurrentPC stable.
  - Advance=1 with NextPC[1:0]==0: CurrentPC<=NextPC, InstrValid<=0, RetiredCount+=1, next state REQ.
  - Advance=1 with NextPC[1:0]!=0: RetiredCount+=1, InstrValid<=0, CurrentPC is unchanged, next state FAULT, code 01.
  - Advance=0: stay in HOLD indefinitely.
- FAULT:
  - imem_req=0, InstrValid=0, Fault=1, FaultCode held.
  - Advance and imem_ready are ignored.
  - Exit only via Reset.
- Ignored inputs: Advance outside HOLD; imem_ready outside REQ.
- Throughput: one instruction per 2 cycles at best (REQ->HOLD->REQ with ready and Advance immediate).
- NextPC==CurrentPC (branch to self) is legal: refetches the same address.
- RetiredCount wraps from all-ones to 0 without flagging a fault.

Decomposition:
- Shared package (processor defines file):
  - state encoding: IDLE=2'd0, REQ=2'd1, HOLD=2'd2, FAULT=2'd3.
  - FaultCode constants FC_NONE, FC_MISALIGN, FC_TIMEOUT.
  - instruction width of 32.
- One sub-module, fetch_timeout_counter: clear/enable inputs, expiry output at TIMEOUT-1, disabled when TIMEOUT=0.
- FSM, PC register, instruction register and retire counter stay in pc_fetch_unit.

Test Plan:
- Reset with RESET_PC=0 -> next cycle IDLE, then imem_req=1 with imem_addr=0x0. Ready with rdata=0xF84003E9 -> Instr=0xF84003E9, InstrValid=1 the following cycle.
- Sequential run: in HOLD, NextPC=0x4, Advance=1 -> imem_addr=0x4, RetiredCount=1. Repeat with NextPC=0x8 -> RetiredCount=2.
- Branch target: CurrentPC=0x4, NextPC=0x36 -> Fault=1, FaultCode=01, CurrentPC stays 0x4. After Reset and a rerun, NextPC=0x38 -> imem_addr=0x38.
- Stall: hold ready low for 5 cycles with TIMEOUT=16 -> imem_req stays 1 with a stable address, then Instr loads on ready. Hold ready low for 16 cycles -> FAULT, code 10, imem_req=0.
- Reset mid-REQ with ready=1 in the same cycle -> Instr=0, InstrValid=0, CurrentPC=RESET_PC, imem_req=0 next cycle.
- Ignored inputs: Advance pulsed in REQ and ready pulsed in HOLD -> no change to state, CurrentPC or RetiredCount.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, fault codes and instruction width.
package pc_fetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetchState_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    function automatic logic isAligned(input logic [63:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ready handshake between the fetch unit and memory.
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    logic               req;
    logic [63:0]        addr;
    logic               ready;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/pc_fetch_unit_fetch_timeout_counter.sv
// Counts cycles a fetch request has waited; expiry fires once the count sits at TIMEOUT-1.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // TIMEOUT of zero means the wait is unbounded.
    assign expired_o = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and fetch FSM: requests the word at the PC, holds it for decode, advances on retire.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [63:0]        nextPc_i,
    input  logic               advance_i,
    pc_fetch_unit_if.master    imem,
    output logic [63:0]        currentPc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instrValid_o,
    output logic               fault_o,
    output logic [1:0]         faultCode_o,
    output logic [CNT_W-1:0]   retiredCount_o
);

    fetchState_e        state_q, state_d;
    logic [63:0]        currentPc_q, currentPc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instrValid_q, instrValid_d;
    logic [1:0]         faultCode_q, faultCode_d;
    logic [CNT_W-1:0]   retiredCount_q, retiredCount_d;
    logic               toClear, toEnable, toExpired;

    fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (toClear),
        .enable_i  (toEnable),
        .expired_o (toExpired)
    );

    always_comb begin
        state_d        = state_q;
        currentPc_d    = currentPc_q;
        instr_d        = instr_q;
        instrValid_d   = instrValid_q;
        faultCode_d    = faultCode_q;
        retiredCount_d = retiredCount_q;
        toClear        = 1'b1;
        toEnable       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!isAligned(RESET_PC)) begin
                    state_d     = FAULT;
                    faultCode_d = FC_MISALIGN;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem.ready) begin
                    instr_d      = imem.rdata;
                    instrValid_d = 1'b1;
                    state_d      = HOLD;
                end else begin
                    toClear  = 1'b0;
                    toEnable = 1'b1;
                    if (toExpired) begin
                        state_d     = FAULT;
                        faultCode_d = FC_TIMEOUT;
                    end
                end
            end
            HOLD: begin
                if (advance_i) begin
                    retiredCount_d = retiredCount_q + CNT_W'(1);
                    instrValid_d   = 1'b0;
                    // A misaligned target still retires the held instruction but keeps the old PC.
                    if (isAligned(nextPc_i)) begin
                        currentPc_d = nextPc_i;
                        state_d     = REQ;
                    end else begin
                        state_d     = FAULT;
                        faultCode_d = FC_MISALIGN;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            currentPc_q    <= RESET_PC;
            instr_q        <= '0;
            instrValid_q   <= 1'b0;
            faultCode_q    <= FC_NONE;
            retiredCount_q <= '0;
        end else begin
            state_q        <= state_d;
            currentPc_q    <= currentPc_d;
            instr_q        <= instr_d;
            instrValid_q   <= instrValid_d;
            faultCode_q    <= faultCode_d;
            retiredCount_q <= retiredCount_d;
        end
    end

    assign imem.req       = (state_q == REQ);
    assign imem.addr      = currentPc_q;
    assign currentPc_o    = currentPc_q;
    assign instr_o        = instr_q;
    assign instrValid_o   = instrValid_q;
    assign fault_o        = (state_q == FAULT);
    assign faultCode_o    = faultCode_q;
    assign retiredCount_o = retiredCount_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic [63:0] nextPc;
    logic        advance;
    logic [63:0] currentPc;
    logic [31:0] instr;
    logic        instrValid;
    logic        fault;
    logic [1:0]  faultCode;
    logic [31:0] retiredCount;
    int          vectors;
    int          miscompares;

    pc_fetch_unit_if imemIf ();

    pc_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .nextPc_i       (nextPc),
        .advance_i      (advance),
        .imem           (imemIf),
        .currentPc_o    (currentPc),
        .instr_o        (instr),
        .instrValid_o   (instrValid),
        .fault_o        (fault),
        .faultCode_o    (faultCode),
        .retiredCount_o (retiredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic [63:0] npc, input logic r, input logic [31:0] rd);
        advance        = a;
        nextPc         = npc;
        imemIf.ready   = r;
        imemIf.rdata   = rd;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst_req", imemIf.req, 1'b0);
        checkOutput("rst_pc", currentPc, 64'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_valid", instrValid, 1'b0);
        checkOutput("rst_fault", {fault, faultCode}, 3'b000);
        checkOutput("rst_retired", retiredCount, 32'd0);

        // IDLE for one cycle, then REQ at address 0
        rst = 1'b0;
        tick();
        checkOutput("first_req", imemIf.req, 1'b1);
        checkOutput("first_addr", imemIf.addr, 64'h0);

        applyStimulus(1'b0, 64'h0, 1'b1, 32'hF84003E9);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        checkOutput("first_instr", instr, 32'hF84003E9);
        checkOutput("first_valid", instrValid, 1'b1);
        checkOutput("hold_req", imemIf.req, 1'b0);

        // ready in HOLD is ignored
        applyStimulus(1'b0, 64'h0, 1'b1, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        checkOutput("ign_ready_instr", instr, 32'hF84003E9);
        checkOutput("ign_ready_valid", instrValid, 1'b1);
        checkOutput("ign_ready_req", imemIf.req, 1'b0);

        applyStimulus(1'b1, 64'h4, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        checkOutput("seq4_addr", imemIf.addr, 64'h4);
        checkOutput("seq4_req", imemIf.req, 1'b1);
        checkOutput("seq4_retired", retiredCount, 32'd1);
        checkOutput("seq4_valid", instrValid, 1'b0);

        // Advance in REQ is ignored; this also starts a 5-cycle stall
        applyStimulus(1'b1, 64'h100, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        checkOutput("ign_adv_addr", imemIf.addr, 64'h4);
        checkOutput("ign_adv_retired", retiredCount, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("stall_req", imemIf.req, 1'b1);
            checkOutput("stall_addr", imemIf.addr, 64'h4);
        end
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h00000013);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        checkOutput("stall_instr", instr, 32'h00000013);
        checkOutput("stall_valid", instrValid, 1'b1);

        applyStimulus(1'b1, 64'h8, 1'b0, 32'h0);
        tick();
        checkOutput("seq8_addr", imemIf.addr, 64'h8);
        checkOutput("seq8_retired", retiredCount, 32'd2);
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h00100093);
        tick();

        // back to 0x4, then branch to a misaligned target
        applyStimulus(1'b1, 64'h4, 1'b0, 32'h0);
        tick();
        checkOutput("back4_addr", imemIf.addr, 64'h4);
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h00200113);
        tick();
        applyStimulus(1'b1, 64'h36, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        checkOutput("mis_fault", fault, 1'b1);
        checkOutput("mis_code", faultCode, FC_MISALIGN);
        checkOutput("mis_pc", currentPc, 64'h4);
        checkOutput("mis_retired", retiredCount, 32'd4);
        checkOutput("mis_req", imemIf.req, 1'b0);
        checkOutput("mis_valid", instrValid, 1'b0);

        applyStimulus(1'b1, 64'h8, 1'b1, 32'h12345678);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        checkOutput("fault_sticky", {fault, faultCode}, {1'b1, FC_MISALIGN});
        checkOutput("fault_pc", currentPc, 64'h4);
        checkOutput("fault_retired", retiredCount, 32'd4);

        // reset clears the fault, rerun and take an aligned branch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("clr_fault", {fault, faultCode}, 3'b000);
        checkOutput("clr_retired", retiredCount, 32'd0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 32'hF84003E9);
        tick();
        applyStimulus(1'b1, 64'h38, 1'b0, 32'h0);
        tick();
        checkOutput("br38_addr", imemIf.addr, 64'h38);
        checkOutput("br38_req", imemIf.req, 1'b1);
        checkOutput("br38_retired", retiredCount, 32'd1);

        // branch to self refetches the same address
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h0000006F);
        tick();
        applyStimulus(1'b1, 64'h38, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        checkOutput("self_addr", imemIf.addr, 64'h38);
        checkOutput("self_req", imemIf.req, 1'b1);
        checkOutput("self_retired", retiredCount, 32'd2);

        // reset mid-REQ with a simultaneous ready
        rst = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b1, 32'hAAAA5555);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0);
        checkOutput("midrst_instr", instr, 32'h0);
        checkOutput("midrst_valid", instrValid, 1'b0);
        checkOutput("midrst_pc", currentPc, 64'h0);
        checkOutput("midrst_req", imemIf.req, 1'b0);

        // timeout: 15 low-ready edges keep waiting, the 16th faults
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        checkOutput("to_wait_req", imemIf.req, 1'b1);
        checkOutput("to_wait_fault", fault, 1'b0);
        tick();
        checkOutput("to_fault", fault, 1'b1);
        checkOutput("to_code", faultCode, FC_TIMEOUT);
        checkOutput("to_req", imemIf.req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
